// File: rtl/packet_sender_pkg.sv
// Shared protocol definitions for the packet sender: FSM states, packet
// layout, word ordering on the radio stream.
package packet_sender_pkg;

  localparam int PKT_WORDS   = 8;
  localparam int IDX_W       = $clog2(PKT_WORDS);
  // Storage width of one packet field; top-level WORD_WIDTH values up to
  // this width are carried without loss.
  localparam int PKT_FIELD_W = 16;

  // Transmit order of the fields within a packet
  localparam logic [IDX_W-1:0] W_PTYPE    = 3'd0;
  localparam logic [IDX_W-1:0] W_SRC_ID   = 3'd1;
  localparam logic [IDX_W-1:0] W_DST_ID   = 3'd2;
  localparam logic [IDX_W-1:0] W_ENERGY   = 3'd3;
  localparam logic [IDX_W-1:0] W_QVALUE   = 3'd4;
  localparam logic [IDX_W-1:0] W_SRC_HOPS = 3'd5;
  localparam logic [IDX_W-1:0] W_CH       = 3'd6;
  localparam logic [IDX_W-1:0] W_HOPS_CH  = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SENSE = 2'd1,
    ST_SEND  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  typedef struct packed {
    logic [PKT_FIELD_W-1:0] ptype;
    logic [PKT_FIELD_W-1:0] src_id;
    logic [PKT_FIELD_W-1:0] dst_id;
    logic [PKT_FIELD_W-1:0] energy;
    logic [PKT_FIELD_W-1:0] qvalue;
    logic [PKT_FIELD_W-1:0] src_hops;
    logic [PKT_FIELD_W-1:0] chosen_ch;
    logic [PKT_FIELD_W-1:0] hops_from_ch;
  } pkt_t;

  // Select the field that goes out at word position idx
  function automatic logic [PKT_FIELD_W-1:0] pkt_word(input pkt_t p, input logic [IDX_W-1:0] idx);
    case (idx)
      W_PTYPE:    pkt_word = p.ptype;
      W_SRC_ID:   pkt_word = p.src_id;
      W_DST_ID:   pkt_word = p.dst_id;
      W_ENERGY:   pkt_word = p.energy;
      W_QVALUE:   pkt_word = p.qvalue;
      W_SRC_HOPS: pkt_word = p.src_hops;
      W_CH:       pkt_word = p.chosen_ch;
      default:    pkt_word = p.hops_from_ch;
    endcase
  endfunction

endpackage

// File: rtl/packet_sender_queue.sv
// Whole-packet FIFO. A pop and a push in the same cycle are both honoured
// even when full: the pop frees the slot the push lands in.
module pkt_queue
  import packet_sender_pkg::*;
#(
  parameter int QDEPTH = 2
) (
  input  logic clk,
  input  logic nrst,
  input  logic push,
  input  logic pop,
  input  pkt_t din,
  output pkt_t head,
  output logic full,
  output logic empty
);

  localparam int AW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW = $clog2(QDEPTH + 1);

  pkt_t            mem [QDEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic            do_push, do_pop;

  function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
    ptr_next = (p == AW'(QDEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count == CW'(QDEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk) begin
    if (nrst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_pop)  rd_ptr <= ptr_next(rd_ptr);
      if (do_push) wr_ptr <= ptr_next(wr_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Packet storage; contents are don't-care while the slot is free
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/packet_sender.sv
// Buffers packed packets from the reward stage and sends each one to the
// radio as an 8-word stream after a clear-channel backoff.
module packet_sender
  import packet_sender_pkg::*;
#(
  parameter int WORD_WIDTH = 16,
  parameter int BACKOFF    = 4,
  parameter int QDEPTH     = 2
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  en,
  input  logic                  reward_done,
  input  logic [WORD_WIDTH-1:0] rPacketType,
  input  logic [WORD_WIDTH-1:0] rSourceID,
  input  logic [WORD_WIDTH-1:0] rDestinationID,
  input  logic [WORD_WIDTH-1:0] rEnergyLeft,
  input  logic [WORD_WIDTH-1:0] rQValue,
  input  logic [WORD_WIDTH-1:0] rSourceHops,
  input  logic [WORD_WIDTH-1:0] rChosenCH,
  input  logic [WORD_WIDTH-1:0] rHopsFromCH,
  input  logic                  channel_busy,
  output logic [WORD_WIDTH-1:0] tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  tx_sop,
  output logic                  tx_eop,
  output logic                  busy,
  output logic                  queue_full,
  output logic                  overflow,
  output logic                  sent_done
);

  localparam int               CNT_W = $clog2(BACKOFF + 1);
  localparam logic [IDX_W-1:0] LAST  = IDX_W'(PKT_WORDS - 1);

  state_t           state;
  logic [CNT_W-1:0] bo_cnt;
  logic [IDX_W-1:0] widx;
  logic             push_req, pop, q_full, q_empty;
  pkt_t             pkt_in, head;

  assign push_req = reward_done & en;
  // The last-word handshake retires the head packet
  assign pop      = (state == ST_SEND) & tx_ready & (widx == LAST);

  assign pkt_in = '{
    ptype:        PKT_FIELD_W'(rPacketType),
    src_id:       PKT_FIELD_W'(rSourceID),
    dst_id:       PKT_FIELD_W'(rDestinationID),
    energy:       PKT_FIELD_W'(rEnergyLeft),
    qvalue:       PKT_FIELD_W'(rQValue),
    src_hops:     PKT_FIELD_W'(rSourceHops),
    chosen_ch:    PKT_FIELD_W'(rChosenCH),
    hops_from_ch: PKT_FIELD_W'(rHopsFromCH)
  };

  pkt_queue #(.QDEPTH(QDEPTH)) u_queue (
    .clk   (clk),
    .nrst  (nrst),
    .push  (push_req),
    .pop   (pop),
    .din   (pkt_in),
    .head  (head),
    .full  (q_full),
    .empty (q_empty)
  );

  // Sender FSM: wait for work, back off on a clear channel, stream, report
  always_ff @(posedge clk) begin
    if (nrst) begin
      state    <= ST_IDLE;
      bo_cnt   <= '0;
      widx     <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_req && q_full && !pop) overflow <= 1'b1;
      case (state)
        ST_IDLE: if (!q_empty && en) begin
          state  <= ST_SENSE;
          bo_cnt <= '0;
        end
        ST_SENSE: begin
          if (channel_busy) begin
            bo_cnt <= '0;
          end else if (bo_cnt == CNT_W'(BACKOFF - 1)) begin
            state  <= ST_SEND;
            bo_cnt <= '0;
            widx   <= '0;
          end else begin
            bo_cnt <= bo_cnt + 1'b1;
          end
        end
        // Once started a packet runs to completion regardless of carrier/en
        ST_SEND: if (tx_ready) begin
          if (widx == LAST) state <= ST_DONE;
          else              widx  <= widx + 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign tx_valid   = (state == ST_SEND);
  assign tx_data    = tx_valid ? WORD_WIDTH'(pkt_word(head, widx)) : '0;
  assign tx_sop     = tx_valid & (widx == '0);
  assign tx_eop     = tx_valid & (widx == LAST);
  assign sent_done  = (state == ST_DONE);
  assign busy       = (state != ST_IDLE) | ~q_empty;
  assign queue_full = q_full;

endmodule

// File: doc/packet_sender.md
PACKET_SENDER -- requirements
Module: packet_sender

Interface
REQ-001 SHALL have parameter WORD_WIDTH, default 16: width of every packet field and of tx_data.
REQ-002 SHALL have parameter BACKOFF, default 4, minimum 1: consecutive clear-channel cycles required before transmitting.
REQ-003 SHALL have parameter QDEPTH, default 2: number of whole packets buffered.
REQ-004 SHALL have port clk, input, 1: the single clock.
REQ-005 SHALL have port nrst, input, 1: reset, synchronous and active-high.
REQ-006 SHALL have port en, input, 1: block enable.
REQ-007 SHALL have port reward_done, input, 1: packed packet valid from the reward stage.
REQ-008 SHALL have ports rPacketType, rSourceID, rDestinationID, rEnergyLeft, rQValue, rSourceHops, rChosenCH, rHopsFromCH, input, WORD_WIDTH each: packet fields.
REQ-009 SHALL have port channel_busy, input, 1: carrier-sense indication.
REQ-010 SHALL have ports tx_data (output, WORD_WIDTH), tx_valid (output, 1), tx_ready (input, 1), tx_sop (output, 1) and tx_eop (output, 1): word stream to the radio.
REQ-011 SHALL have ports busy (output, 1), queue_full (output, 1), overflow (output, 1) and sent_done (output, 1): status.

Function
REQ-012 SHALL push all eight fields into the queue at a rising edge where reward_done=1, en=1 and the queue is not full.
REQ-013 SHALL drop the packet when reward_done=1, en=1 and the queue is full, and SHALL set overflow, which stays set until reset.
REQ-014 SHALL accept a push when the queue is full if the last word handshakes in the same cycle; the pop happens first.
REQ-015 SHALL ignore reward_done while en=0.
REQ-016 SHALL implement the FSM states IDLE, SENSE, SEND and DONE.
REQ-017 SHALL move from IDLE to SENSE when the queue is non-empty and en=1, clearing the backoff counter.
REQ-018 SHALL, in SENSE, increment the counter on each cycle with channel_busy=0 and reset it to 0 on any cycle with channel_busy=1.
REQ-019 SHALL move from SENSE to SEND after BACKOFF consecutive clear cycles.
REQ-020 SHALL ignore channel_busy and en in SEND, so a packet is never aborted once started.
REQ-021 SHALL emit the head packet in SEND in the word order PacketType, SourceID, DestinationID, EnergyLeft, QValue, SourceHops, ChosenCH, HopsFromCH.
REQ-022 SHALL hold tx_valid=1 throughout SEND and advance the word index only when tx_valid=1 and tx_ready=1.
REQ-023 SHALL hold tx_data, tx_sop and tx_eop stable while tx_ready=0.
REQ-024 SHALL assert tx_sop only with word 0 and tx_eop only with word 7.
REQ-025 SHALL pop the queue and move to DONE on the word-7 handshake.
REQ-026 SHALL hold sent_done=1 for exactly the single DONE cycle, then return to IDLE.
REQ-027 SHALL start every packet, including back-to-back packets, from a fresh SENSE phase.
REQ-028 SHALL give a latency, with no stall and channel clear, of: reward_done in cycle 0, IDLE in cycle 1, SENSE in cycles 2..BACKOFF+1, first tx_valid in cycle BACKOFF+2.
REQ-029 SHALL drive busy=1 whenever state is not IDLE or the queue is non-empty.
REQ-030 SHALL drive queue_full=1 exactly when the count equals QDEPTH.
REQ-031 SHALL drive tx_data to 0 whenever tx_valid=0.

Reset
REQ-032 SHALL, while nrst=1 at a rising edge, force state IDLE, empty the queue, and clear the backoff counter and word index.
REQ-033 SHALL, under the same reset, clear tx_data, tx_valid, tx_sop, tx_eop, busy, queue_full, overflow and sent_done to 0.
REQ-034 SHALL let reset asserted mid-packet discard the partial and queued packets, with no tx_eop emitted.

Structure
REQ-035 SHALL place the state enum, PKT_WORDS=8, the word-index constants and the packed packet struct in the shared protocol package.
REQ-036 SHALL implement the QDEPTH-entry packet FIFO as sub-module pkt_queue, carrying the packet struct with push/pop/full/empty ports.

Verification
REQ-037 SHALL cover nominal send: BACKOFF=4, channel clear, tx_ready=1, fields 1..8 -> tx_valid first in cycle 6, tx_data 1..8 in order, sop on 1, eop on 8, sent_done in cycle 14.
REQ-038 SHALL cover busy channel: channel_busy=1 in the 2nd SENSE cycle -> counter restarts, first tx_valid delayed to cycle 8.
REQ-039 SHALL cover stall: tx_ready=0 for 3 cycles at word 3 -> word 3 held stable, 8 words total, no duplicates.
REQ-040 SHALL cover overflow: three reward_done pulses on consecutive cycles with QDEPTH=2 -> queue_full=1 and overflow=1, third packet dropped, first two sent in order.
REQ-041 SHALL cover simultaneous push/pop: reward_done with queue full in the word-7 handshake cycle -> push accepted, overflow stays 0.
REQ-042 SHALL cover reset mid-packet: nrst=1 at word 4 -> all outputs 0 next cycle, queue empty, no tx_eop.
